msx_audio_mixer: RTL and testbench

- Consumes the three raw sound sources from the MSX core: PSG (10-bit unsigned), OPLL (14-bit signed) and PCM (16-bit signed).
- Scales and sums them, then saturates the result to a single 16-bit signed sample.
- Feeds AUDIO_L/AUDIO_R (AUDIO_S=1) and drives a clip-activity indicator usable as an LED source.
- Replaces the combinational adder/compressor at the top level with a registered, strobe-qualified pipeline. An optional DC-removal stage can be compiled in.

---
 rtl/msx_audio_mixer_if.sv | 21 ++
 rtl/msx_audio_mixer.sv | 162 ++++++++++++++++
 tb/tb_msx_audio_mixer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/msx_audio_mixer_if.sv
// Sample bus between the MSX core sound sources and the audio mixer.
// The master drives the raw levels and strobe; the slave returns the mixed sample.
interface msx_audio_mixer_if;
  logic        ce_sample;
  logic [9:0]  psg;
  logic [13:0] opll;
  logic [15:0] pcm;
  logic [15:0] audio_out;
  logic        out_valid;
  logic        clip;

  modport master (
    output ce_sample, psg, opll, pcm,
    input  audio_out, out_valid, clip
  );

  modport slave (
    input  ce_sample, psg, opll, pcm,
    output audio_out, out_valid, clip
  );
endinterface

// File: rtl/msx_audio_mixer.sv
// Registered PSG/OPLL/PCM mixer with 16-bit saturation and clip-hold indicator.
// Define MSX_AUDIO_DCBLOCK_EN to insert the DC-removal stage (latency 3 -> 4).
module msx_audio_mixer #(
  parameter int PSG_SHIFT  = 5,
  parameter int OPLL_SHIFT = 2,
  parameter int CLIP_HOLD  = 4800
`ifdef MSX_AUDIO_DCBLOCK_EN
  ,
  parameter int DCB_K      = 10
`endif
) (
  input  logic             clk_sys,
  input  logic             reset,
  msx_audio_mixer_if.slave bus
);

  // Returns {clamped, value}.
  function automatic logic [16:0] sat17(input logic [16:0] s);
    if (s[16] == s[15]) begin
      return {1'b0, s[15:0]};
    end
    return {1'b1, (s[16] ? 16'h8000 : 16'h7FFF)};
  endfunction

  logic        r_s1_v;
  logic [15:0] r_s1_fm;
  logic [15:0] r_s1_pcm;
  logic        r_s2_v;
  logic [16:0] r_s2_sum;
  logic        r_s3_v;
  logic [15:0] r_s3_res;
  logic        r_s3_sat;
  logic [15:0] r_audio;
  logic        r_valid;
  logic [15:0] r_cnt;
  logic        r_clip;

  logic [15:0] w_opll16;
  logic [15:0] w_psg16;
  logic [15:0] w_fm;
  logic [16:0] w_sum;
  logic [16:0] w_s3;
  logic        w_o_v;
  logic [15:0] w_o_res;
  logic        w_o_sat;

  assign w_opll16 = {{2{bus.opll[13]}}, bus.opll};
  assign w_psg16  = {6'd0, bus.psg};
  assign w_fm     = (w_opll16 << OPLL_SHIFT) + (w_psg16 << PSG_SHIFT);
  assign w_sum    = {r_s1_pcm[15], r_s1_pcm} + {r_s1_fm[15], r_s1_fm};
  assign w_s3     = sat17(r_s2_sum);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_s1_v   <= 1'b0;
      r_s1_fm  <= '0;
      r_s1_pcm <= '0;
      r_s2_v   <= 1'b0;
      r_s2_sum <= '0;
      r_s3_v   <= 1'b0;
      r_s3_res <= '0;
      r_s3_sat <= 1'b0;
    end else begin
      r_s1_v <= bus.ce_sample;
      r_s2_v <= r_s1_v;
      r_s3_v <= r_s2_v;
      if (bus.ce_sample) begin
        r_s1_fm  <= w_fm;
        r_s1_pcm <= bus.pcm;
      end
      if (r_s1_v) begin
        r_s2_sum <= w_sum;
      end
      if (r_s2_v) begin
        r_s3_res <= w_s3[15:0];
        r_s3_sat <= w_s3[16];
      end
    end
  end

`ifdef MSX_AUDIO_DCBLOCK_EN
  logic        [31:0] r_dc_acc;
  logic               r_s4_v;
  logic        [15:0] r_s4_res;
  logic               r_s4_sat;
  logic signed [31:0] w_dc;
  logic signed [31:0] w_res32;
  logic signed [31:0] w_y32;
  logic        [15:0] w_y;
  logic               w_y_sat;

  assign w_dc    = $signed(r_dc_acc) >>> DCB_K;
  assign w_res32 = $signed({{16{r_s3_res[15]}}, r_s3_res});
  assign w_y32   = w_res32 - w_dc;

  // Tracker keeps dc within 16-bit range, so this equals the 17-bit clamp.
  always_comb begin
    w_y     = w_y32[15:0];
    w_y_sat = 1'b0;
    if (w_y32 > 32'sd32767) begin
      w_y     = 16'h7FFF;
      w_y_sat = 1'b1;
    end else if (w_y32 < -32'sd32768) begin
      w_y     = 16'h8000;
      w_y_sat = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_dc_acc <= '0;
      r_s4_v   <= 1'b0;
      r_s4_res <= '0;
      r_s4_sat <= 1'b0;
    end else begin
      r_s4_v <= r_s3_v;
      if (r_s3_v) begin
        r_dc_acc <= r_dc_acc + w_res32 - w_dc;
        r_s4_res <= w_y;
        r_s4_sat <= r_s3_sat | w_y_sat;
      end
    end
  end

  assign w_o_v   = r_s4_v;
  assign w_o_res = r_s4_res;
  assign w_o_sat = r_s4_sat;
`else
  assign w_o_v   = r_s3_v;
  assign w_o_res = r_s3_res;
  assign w_o_sat = r_s3_sat;
`endif

  // Counter and clip move together so clip rises with the clamped sample.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_audio <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
      r_clip  <= 1'b0;
    end else begin
      r_valid <= w_o_v;
      if (w_o_v) begin
        r_audio <= w_o_res;
        if (w_o_sat) begin
          r_cnt  <= 16'(CLIP_HOLD);
          r_clip <= 1'b1;
        end else if (r_cnt != 16'd0) begin
          r_cnt  <= r_cnt - 16'd1;
          r_clip <= (r_cnt != 16'd1);
        end else begin
          r_clip <= 1'b0;
        end
      end
    end
  end

  assign bus.audio_out = r_audio;
  assign bus.out_valid = r_valid;
  assign bus.clip      = r_clip;

endmodule

// File: tb/tb_msx_audio_mixer.sv
// Random and directed bench for msx_audio_mixer against an arithmetic model.
// Honours MSX_AUDIO_DCBLOCK_EN (DCB_K=6, latency 4).
`timescale 1ns/1ps
module tb_msx_audio_mixer;
  localparam int HOLD = 4800;
  localparam int PS   = 5;
  localparam int OS   = 2;
`ifdef MSX_AUDIO_DCBLOCK_EN
  localparam int LAT  = 4;
  localparam int K    = 6;
`else
  localparam int LAT  = 3;
`endif

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;

  msx_audio_mixer_if bus();

  msx_audio_mixer #(
    .PSG_SHIFT (PS),
    .OPLL_SHIFT(OS),
    .CLIP_HOLD (HOLD)
`ifdef MSX_AUDIO_DCBLOCK_EN
    ,
    .DCB_K     (K)
`endif
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int due;
    int val;
    bit sat;
  } exp_t;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  exp_t   q[$];
  logic [15:0] exp_audio = '0;
  bit     exp_clip = 0;
  int     clip_cnt = 0;
  longint acc = 0;
  bit     dc_mono = 0;
  int     prev_out = 32767;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cyc %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic int clamp(input int v, inout bit sat);
    if (v > 32767) begin
      sat = 1;
      return 32767;
    end
    if (v < -32768) begin
      sat = 1;
      return -32768;
    end
    return v;
  endfunction

  task automatic model_push(input int p, input int o, input int m);
    int   fm;
    int   r;
    bit   sat;
    exp_t e;
    if (o >= 8192) o = o - 16384;
    if (m >= 32768) m = m - 65536;
    fm = (o * (1 << OS) + p * (1 << PS)) & 32'hFFFF;
    if (fm >= 32768) fm = fm - 65536;
    sat = 0;
    r = clamp(m + fm, sat);
`ifdef MSX_AUDIO_DCBLOCK_EN
    begin
      int dc;
      dc = int'(acc >>> K);
      acc = acc + r - dc;
      r = clamp(r - dc, sat);
    end
`endif
    e.due = cyc + 1 + LAT;
    e.val = r;
    e.sat = sat;
    q.push_back(e);
  endtask

  // Checks every output every clock, 1ns after the edge.
  initial begin
    exp_t e;
    int   v;
    forever begin
      @(posedge clk_sys);
      cyc++;
      #1;
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        exp_audio = e.val[15:0];
        if (e.sat) clip_cnt = HOLD;
        else if (clip_cnt > 0) clip_cnt--;
        exp_clip = (clip_cnt != 0);
        chk("out_valid", bus.out_valid, 1);
        if (dc_mono) begin
          v = $signed(bus.audio_out);
          chk("dc_mono", (v <= prev_out), 1);
          prev_out = v;
        end
      end else begin
        chk("idle_valid", bus.out_valid, 0);
      end
      chk("audio_out", bus.audio_out, exp_audio);
      chk("clip", bus.clip, exp_clip);
    end
  end

  task automatic do_reset(input int n);
    reset = 1'b1;
    bus.ce_sample = 1'b0;
    q.delete();
    exp_audio = '0;
    exp_clip = 0;
    clip_cnt = 0;
    acc = 0;
    repeat (n) @(negedge clk_sys);
    reset = 1'b0;
  endtask

  task automatic send(input int p, input int o, input int m, input int gap);
    bus.ce_sample = 1'b1;
    bus.psg  = 10'(p);
    bus.opll = 14'(o);
    bus.pcm  = 16'(m);
    model_push(p, o, m);
    @(negedge clk_sys);
    bus.ce_sample = 1'b0;
    repeat (gap) begin
      bus.psg  = 10'($urandom);
      bus.opll = 14'($urandom);
      bus.pcm  = 16'($urandom);
      @(negedge clk_sys);
    end
  endtask

  initial begin
    int start;
    int v;
    bus.ce_sample = 1'b0;
    bus.psg  = '0;
    bus.opll = '0;
    bus.pcm  = '0;
    @(negedge clk_sys);
    do_reset(2);
    repeat (100) @(negedge clk_sys);

    send(10'h010, 14'h0010, 16'h0100, LAT);
    chk("basic_mix", bus.audio_out, 16'h0340);
    chk("basic_clip", bus.clip, 0);

    do_reset(2);
    send(10'h3FF, 0, 16'h7000, LAT);
    chk("pos_clip_val", bus.audio_out, 16'h7FFF);
    chk("pos_clip_led", bus.clip, 1);
    for (int i = 1; i <= HOLD; i++) begin
      send(0, 0, 0, LAT);
      if (i == HOLD - 1) chk("clip_hold_end", bus.clip, 1);
      if (i == HOLD) chk("clip_fall", bus.clip, 0);
    end

    do_reset(2);
    send(0, 14'h2000, 16'h8000, LAT);
    chk("neg_clip_val", bus.audio_out, 16'h8000);
    chk("neg_clip_led", bus.clip, 1);

    do_reset(2);
    start = cyc;
    for (int i = 1; i <= 8; i++) send(0, 0, i, 0);
    while (cyc < start + 5 + LAT) @(negedge clk_sys);
    chk("b2b_pulse5", bus.audio_out, 16'd5);
    do_reset(1);
    repeat (LAT + 4) begin
      @(negedge clk_sys);
      chk("rst_flush_valid", bus.out_valid, 0);
      chk("rst_flush_audio", bus.audio_out, 0);
    end

    do_reset(2);
    repeat (400) begin
      send($urandom_range(0, 1023), $urandom_range(0, 16383),
           $urandom_range(0, 65535), $urandom_range(0, 3));
    end
    repeat (LAT + 3) @(negedge clk_sys);

`ifdef MSX_AUDIO_DCBLOCK_EN
    do_reset(2);
    prev_out = 32767;
    dc_mono = 1;
    send(10'h200, 0, 0, LAT);
    chk("dc_first", bus.audio_out, 16'h4000);
    repeat (1999) send(10'h200, 0, 0, 0);
    repeat (LAT + 2) @(negedge clk_sys);
    dc_mono = 0;
    v = $signed(bus.audio_out);
    chk("dc_settle", (v <= 2 && v >= -2), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
